// File: rtl/wb_slave_scr_mem.sv
// rtl/wb_slave_scr_mem.sv - Wishbone B3 classic single-access slave with on-chip word RAM
//
// Purpose: target end of the SCR1 Wishbone bridge. Serves one read or write per
// cyc/stb request, with byte lanes and a fixed number of programmable wait states.
//
// Ports:
//   wb_clk_i   in   1   bus clock, rising edge
//   wb_rst_i   in   1   asynchronous active-high reset
//   wbs_adr_i  in   32  byte address, bits [1:0] ignored
//   wbs_dat_i  in   32  write data
//   wbs_dat_o  out  32  read data, valid while wbs_ack_o=1, held until next read
//   wbs_we_i   in   1   1=write, 0=read
//   wbs_sel_i  in   4   byte enables, bit n -> dat[8n+7:8n]
//   wbs_stb_i  in   1   strobe
//   wbs_cyc_i  in   1   bus cycle valid
//   wbs_ack_o  out  1   one-cycle transfer-done pulse
//   wbs_err_o  out  1   one-cycle address-error pulse (present only with WB_SLAVE_ERR_EN)
//
// Configuration macro: WB_SLAVE_ERR_EN
//   defined   - out-of-range accesses pulse wbs_err_o instead of wbs_ack_o
//   undefined - out-of-range writes are dropped, reads return 0, both are acked

module wb_slave_scr_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
`ifdef WB_SLAVE_ERR_EN
  output logic        wbs_err_o,
`endif
  output logic        wbs_ack_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_W  = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [29:0] adr_q;
  logic [31:0] wdat_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic        ack_q;
  logic [31:0] rdat_q;
`ifdef WB_SLAVE_ERR_EN
  logic        err_q;
`endif

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          req;
  logic [29:0]   off_w;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          fire;
  logic          mem_we;
  logic          unused_adr_bits;

  // Byte offset bits never select anything: the memory is word-organised.
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  assign req = wbs_cyc_i & wbs_stb_i;

  // BASE_ADDR is word aligned, so the decode can work on word addresses; the
  // subtraction wraps, hence the explicit lower-bound check.
  assign off_w    = adr_q - BASE_W;
  assign in_range = (adr_q >= BASE_W) && (off_w < DEPTH_W);
  assign idx      = off_w[AW-1:0];

  // fire marks the edge that enters RESP; the request must still be held here,
  // otherwise the transfer is treated as aborted.
  assign fire   = (state_q == S_WAIT) && req && (cnt_q == WS_L);
  assign mem_we = fire && we_q && in_range;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 30'd0;
      wdat_q  <= 32'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdat_q  <= 32'd0;
`ifdef WB_SLAVE_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
          err_q <= 1'b0;
`endif
          if (req) begin
            adr_q   <= wbs_adr_i[31:2];
            wdat_q  <= wbs_dat_i;
            we_q    <= wbs_we_i;
            sel_q   <= wbs_sel_i;
            cnt_q   <= 4'd0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_IDLE;
          end else if (cnt_q == WS_L) begin
            state_q <= S_RESP;
`ifdef WB_SLAVE_ERR_EN
            if (in_range) begin
              ack_q <= 1'b1;
              if (!we_q) rdat_q <= mem_q[idx];
            end else begin
              err_q <= 1'b1;
            end
`else
            ack_q <= 1'b1;
            if (!we_q) rdat_q <= in_range ? mem_q[idx] : 32'h0;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_RESP: begin
          ack_q   <= 1'b0;
`ifdef WB_SLAVE_ERR_EN
          err_q   <= 1'b0;
`endif
          state_q <= S_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Memory is deliberately not reset; a reset drops the FSM out of WAIT so a
  // pending write can never reach fire.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem_q[idx][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
`ifdef WB_SLAVE_ERR_EN
  assign wbs_err_o = err_q;
`endif

endmodule

// File: tb/tb_wb_slave_scr_mem.sv
// tb/tb_wb_slave_scr_mem.sv - self-checking bench for wb_slave_scr_mem (WAIT_STATES 0 and 3)

module tb_wb_slave_scr_mem;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = 32'd0;
  logic [31:0] wdat = 32'd0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        cyc0 = 1'b0, stb0 = 1'b0, cyc1 = 1'b0, stb1 = 1'b0;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, err0, err1;

  always #5 clk = ~clk;

  wb_slave_scr_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat0),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb0), .wbs_cyc_i(cyc0),
`ifdef WB_SLAVE_ERR_EN
    .wbs_err_o(err0),
`endif
    .wbs_ack_o(ack0)
  );

  wb_slave_scr_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat1),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_stb_i(stb1), .wbs_cyc_i(cyc1),
`ifdef WB_SLAVE_ERR_EN
    .wbs_err_o(err1),
`endif
    .wbs_ack_o(ack1)
  );

`ifndef WB_SLAVE_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [2][DEPTH];
  logic [31:0] last_rd [2];
  int          checks = 0;
  int          errors = 0;

  // Reference model: computes the expected response and updates the model memory.
  task automatic push_exp(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] dv, input logic [3:0] s);
    exp_t e;
    logic inr;
    int   idx;
    inr   = (a >= BASE) && ((a - BASE) < SPAN);
    idx   = int'((a - BASE) >> 2);
    e.err = ERR_EN && !inr;
    e.lat = (d == 1) ? 5 : 2;
    if (w) begin
      e.dat = last_rd[d];
      if (inr)
        for (int b = 0; b < 4; b++)
          if (s[b]) model[d][idx][8*b +: 8] = dv[8*b +: 8];
    end else begin
      if (inr) e.dat = model[d][idx];
      else     e.dat = ERR_EN ? last_rd[d] : 32'h0;
      last_rd[d] = e.dat;
    end
    exp_q.push_back(e);
  endtask

  // Bus driver: starts at a falling edge, holds the request until ack/err or timeout.
  task automatic bus(input int d, input logic w, input logic [31:0] a, input logic [31:0] dv,
                     input logic [3:0] s, output int lat, output logic ak, output logic er,
                     output logic [31:0] rd, output logic one);
    adr = a; wdat = dv; we = w; sel = s;
    if (d == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end
    else        begin cyc1 = 1'b1; stb1 = 1'b1; end
    lat = 0; ak = 1'b0; er = 1'b0; rd = 32'd0;
    while (lat < 40 && !ak && !er) begin
      @(negedge clk);
      lat++;
      ak = (d == 0) ? ack0 : ack1;
      er = (d == 0) ? err0 : err1;
      rd = (d == 0) ? dat0 : dat1;
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk);
    one = (d == 0) ? !(ack0 | err0) : !(ack1 | err1);
  endtask

  task automatic test_reset();
    exp_t e; int lat; logic ak, er, one; logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    checks++;
    if ({ack0, ack1, err0, err1} !== 4'b0 || dat0 !== 32'h0 || dat1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ack=%b%b err=%b%b dat=%h/%h, want all zero", ack0, ack1, err0, err1, dat0, dat1);
    end
    for (int i = 0; i < 2; i++) begin
      push_exp(1, i == 0, BASE + 32'h8, 32'h1234_5678, 4'hF);
      bus(1, i == 0, BASE + 32'h8, 32'h1234_5678, 4'hF, lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== !e.err || er !== e.err || !one || rd !== e.dat) begin
        errors++;
        $display("FAIL reset_prep[%0d]: lat=%0d ack=%b err=%b one=%b dat=%h, want lat=%0d err=%b dat=%h", i, lat, ak, er, one, rd, e.lat, e.err, e.dat);
      end
    end
    adr = BASE + 32'h8; wdat = 32'hFFFF_FFFF; we = 1'b1; sel = 4'hF;
    cyc1 = 1'b1; stb1 = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ack1 !== 1'b0 || err1 !== 1'b0 || dat1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_wait: ack=%b err=%b dat=%h, want 0 0 00000000", ack1, err1, dat1);
    end
    cyc1 = 1'b0; stb1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    push_exp(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF);
    bus(1, 1'b0, BASE + 32'h8, 32'h0, 4'hF, lat, ak, er, rd, one);
    e = exp_q.pop_front();
    checks++;
    if (lat !== e.lat || ak !== 1'b1 || rd !== e.dat) begin
      errors++;
      $display("FAIL reset_word_kept: lat=%0d ack=%b dat=%h, want lat=%0d ack=1 dat=%h", lat, ak, rd, e.lat, e.dat);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] addrs [3];
    logic [31:0] vals [3];
    exp_t e; int lat; logic ak, er, one; logic [31:0] rd;
    addrs = '{BASE + 32'h10, BASE, BASE + SPAN - 32'h4};
    vals  = '{32'hDEAD_BEEF, 32'h0123_4567, 32'hA5A5_5A5A};
    for (int i = 0; i < 6; i++) begin
      push_exp(0, i < 3, addrs[i % 3], vals[i % 3], 4'hF);
      bus(0, i < 3, addrs[i % 3], vals[i % 3], 4'hF, lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== !e.err || er !== e.err || !one || rd !== e.dat) begin
        errors++;
        $display("FAIL write_read[%0d]: lat=%0d ack=%b err=%b one=%b dat=%h, want lat=%0d err=%b dat=%h", i, lat, ak, er, one, rd, e.lat, e.err, e.dat);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic        ws [5];
    logic [31:0] vs [5];
    logic [3:0]  ss [5];
    exp_t e; int lat; logic ak, er, one; logic [31:0] rd;
    ws = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vs = '{32'h1122_3344, 32'hAABB_CCDD, 32'h0, 32'hFFFF_FFFF, 32'h0};
    ss = '{4'hF, 4'b0101, 4'b0011, 4'b0000, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      push_exp(0, ws[i], BASE + 32'h20, vs[i], ss[i]);
      bus(0, ws[i], BASE + 32'h20, vs[i], ss[i], lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== !e.err || er !== e.err || !one || rd !== e.dat) begin
        errors++;
        $display("FAIL byte_lanes[%0d]: lat=%0d ack=%b err=%b one=%b dat=%h, want lat=%0d err=%b dat=%h", i, lat, ak, er, one, rd, e.lat, e.err, e.dat);
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e; int lat; logic ak, er, one; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      push_exp(1, i == 0, BASE + 32'h40, 32'h5A5A_0F0F, 4'hF);
      bus(1, i == 0, BASE + 32'h40, 32'h5A5A_0F0F, 4'hF, lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== !e.err || er !== e.err || !one || rd !== e.dat) begin
        errors++;
        $display("FAIL wait_states[%0d]: lat=%0d ack=%b err=%b one=%b dat=%h, want lat=%0d err=%b dat=%h", i, lat, ak, er, one, rd, e.lat, e.err, e.dat);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e; int lat; logic ak, er, one, seen; logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      push_exp(d, 1'b1, BASE + 32'h30, 32'hC0FF_EE00 + 32'(d), 4'hF);
      bus(d, 1'b1, BASE + 32'h30, 32'hC0FF_EE00 + 32'(d), 4'hF, lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== 1'b1 || !one) begin
        errors++;
        $display("FAIL abort_prep[%0d]: lat=%0d ack=%b one=%b, want lat=%0d ack=1", d, lat, ak, one, e.lat);
      end
      // WAIT_STATES=0 drops stb right before the RESP entry edge, WAIT_STATES=3 mid-WAIT.
      adr = BASE + 32'h30; wdat = 32'h5555_5555; we = 1'b1; sel = 4'hF;
      if (d == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end
      else        begin cyc1 = 1'b1; stb1 = 1'b1; end
      repeat (d + 1) @(negedge clk);
      stb0 = 1'b0; stb1 = 1'b0;
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        seen = seen | ((d == 0) ? (ack0 | err0) : (ack1 | err1));
      end
      cyc0 = 1'b0; cyc1 = 1'b0;
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_ack[%0d]: response seen=%b, want 0", d, seen);
      end
      push_exp(d, 1'b0, BASE + 32'h30, 32'h0, 4'hF);
      bus(d, 1'b0, BASE + 32'h30, 32'h0, 4'hF, lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== 1'b1 || !one || rd !== e.dat) begin
        errors++;
        $display("FAIL abort_after[%0d]: lat=%0d ack=%b one=%b dat=%h, want lat=%0d ack=1 dat=%h", d, lat, ak, one, rd, e.lat, e.dat);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic        ws [5];
    logic [31:0] as [5];
    exp_t e; int lat; logic ak, er, one; logic [31:0] rd;
    ws = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    as = '{BASE + 32'h10, BASE + SPAN, BASE - 32'h4, BASE + SPAN, BASE};
    for (int i = 0; i < 5; i++) begin
      push_exp(0, ws[i], as[i], 32'hBAD0_BAD0, 4'hF);
      bus(0, ws[i], as[i], 32'hBAD0_BAD0, 4'hF, lat, ak, er, rd, one);
      e = exp_q.pop_front();
      checks++;
      if (lat !== e.lat || ak !== !e.err || er !== e.err || !one || rd !== e.dat) begin
        errors++;
        $display("FAIL out_of_range[%0d]: lat=%0d ack=%b err=%b one=%b dat=%h, want lat=%0d err=%b dat=%h", i, lat, ak, er, one, rd, e.lat, e.err, e.dat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_ack;
    logic [31:0] exp_dat;
    exp_dat = model[0][4];
    adr = BASE + 32'h10; we = 1'b0; sel = 4'hF;
    cyc0 = 1'b1; stb0 = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      exp_ack = (n % 3 == 2);
      checks++;
      if (ack0 !== exp_ack || (exp_ack && dat0 !== exp_dat)) begin
        errors++;
        $display("FAIL back_to_back[cycle %0d]: ack=%b dat=%h, want ack=%b dat=%h", n, ack0, dat0, exp_ack, exp_dat);
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0;
    last_rd[0] = exp_dat;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_abort();
    test_out_of_range();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
